// File: rtl/mvu_dma_wb_pkg.sv
// Shared definitions for the MVU write-back DMA: register offsets, CTRL/STATUS
// bit indices, FSM state encoding and the register-map decode helper.
package mvu_dma_wb_pkg;

   // Register offsets within the ICB window (address bits [4:0]).
   localparam logic [4:0] RegSrc    = 5'h00;
   localparam logic [4:0] RegDst    = 5'h04;
   localparam logic [4:0] RegSize   = 5'h08;
   localparam logic [4:0] RegCtrl   = 5'h0C;
   localparam logic [4:0] RegStatus = 5'h10;

   // CTRL bits.
   localparam int unsigned CtrlStartBit = 0;
   localparam int unsigned CtrlIrqEnBit = 1;

   // STATUS bits.
   localparam int unsigned StatusBusyBit = 0;
   localparam int unsigned StatusDoneBit = 1;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StWrLo,
      StWrHi,
      StDone
   } state_e;

   function automatic logic reg_mapped(input logic [4:0] off);
      return (off == RegSrc) || (off == RegDst) || (off == RegSize) ||
             (off == RegCtrl) || (off == RegStatus);
   endfunction

endpackage

// File: rtl/mvu_dma_wb_reg.sv
// ICB slave and register file of the MVU write-back DMA.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_icb_cmd_* / rsp_*   E203 ICB slave (XLEN 32), one-cycle registered response
//   cfg_src/dst/size      programmed transfer parameters
//   start                 single-cycle start pulse (only while idle)
//   busy                  transfer engine busy (ignores config writes and start)
//   done_set              engine completion; wins over a same-cycle W1C
//   irq                   level interrupt = done & irq_en
module mvu_dma_wb_reg
   import mvu_dma_wb_pkg::*;
#(
   parameter int unsigned MVU_AW = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_icb_cmd_valid,
   output logic              i_icb_cmd_ready,
   input  logic [31:0]       i_icb_cmd_addr,
   input  logic              i_icb_cmd_read,
   input  logic [31:0]       i_icb_cmd_wdata,
   input  logic [3:0]        i_icb_cmd_wmask,
   output logic              i_icb_rsp_valid,
   input  logic              i_icb_rsp_ready,
   output logic              i_icb_rsp_err,
   output logic [31:0]       i_icb_rsp_rdata,
   output logic [MVU_AW-1:0] cfg_src,
   output logic [31:0]       cfg_dst,
   output logic [15:0]       cfg_size,
   output logic              start,
   input  logic              busy,
   input  logic              done_set,
   output logic              irq
);

   logic [MVU_AW-1:0] src_q, src_d;
   logic [31:0]       dst_q, dst_d;
   logic [15:0]       size_q, size_d;
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic [31:0]       rdata_mux;
   logic [4:0]        off;
   logic              mapped, cmd_fire, wr_fire;
   logic              unused_icb;

   // Full-word writes only; upper address bits are decoded upstream.
   assign unused_icb = ^{i_icb_cmd_wmask, i_icb_cmd_addr[31:5]};

   assign off             = i_icb_cmd_addr[4:0];
   assign mapped          = reg_mapped(off);
   assign i_icb_cmd_ready = !rsp_valid_q | i_icb_rsp_ready;
   assign cmd_fire        = i_icb_cmd_valid & i_icb_cmd_ready;
   assign wr_fire         = cmd_fire & !i_icb_cmd_read & mapped;
   assign start           = wr_fire & (off == RegCtrl) & i_icb_cmd_wdata[CtrlStartBit] & !busy;

   assign cfg_src         = src_q;
   assign cfg_dst         = dst_q;
   assign cfg_size        = size_q;
   assign irq             = done_q & irq_en_q;
   assign i_icb_rsp_valid = rsp_valid_q;
   assign i_icb_rsp_err   = rsp_err_q;
   assign i_icb_rsp_rdata = rsp_rdata_q;

   always_comb begin
      rdata_mux = '0;
      case (off)
         RegSrc:    rdata_mux = 32'(src_q);
         RegDst:    rdata_mux = dst_q;
         RegSize:   rdata_mux = 32'(size_q);
         RegCtrl:   rdata_mux[CtrlIrqEnBit] = irq_en_q;
         RegStatus: begin
            rdata_mux[StatusBusyBit] = busy;
            rdata_mux[StatusDoneBit] = done_q;
         end
         default:   rdata_mux = '0;
      endcase
   end

   always_comb begin
      src_d       = src_q;
      dst_d       = dst_q;
      size_d      = size_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      if (wr_fire && !busy) begin
         if (off == RegSrc)  src_d  = i_icb_cmd_wdata[MVU_AW-1:0];
         if (off == RegDst)  dst_d  = i_icb_cmd_wdata;
         if (off == RegSize) size_d = i_icb_cmd_wdata[15:0];
      end
      if (wr_fire && off == RegCtrl) irq_en_d = i_icb_cmd_wdata[CtrlIrqEnBit];
      if (start) done_d = 1'b0;
      if (wr_fire && off == RegStatus && i_icb_cmd_wdata[StatusDoneBit]) done_d = 1'b0;
      // Hardware completion takes priority over a software clear in the same cycle.
      if (done_set) done_d = 1'b1;

      if (cmd_fire) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = !mapped;
         rsp_rdata_d = (i_icb_cmd_read && mapped) ? rdata_mux : 32'h0;
      end else if (i_icb_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q       <= '0;
         dst_q       <= '0;
         size_q      <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         src_q       <= src_d;
         dst_q       <= dst_d;
         size_q      <= size_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule

// File: rtl/mvu_dma_wb.sv
// MVU write-back DMA: reads 64-bit words from MVU data RAM and writes them to
// system memory as two 32-bit beats, low half first.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mvu_rd_*                     MVU data-RAM read request / response
//   dest_address/data/valid/ready system write beat channel
//   i_icb_*                      ICB slave register window
//   dma_irq                      level IRQ = status.done & ctrl.irq_en
// Configuration macro MVU_DMA_WB_PREFETCH_EN: when defined, the next MVU read is
// issued while the current word is still being written (one-word buffer, at most
// one outstanding read). When undefined, reads are strictly sequential.
module mvu_dma_wb
   import mvu_dma_wb_pkg::*;
#(
   parameter int unsigned MVU_AW = 15,
   parameter int unsigned MVU_DW = 64,
   parameter int unsigned SYS_DW = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [MVU_AW-1:0] mvu_rd_address,
   output logic              mvu_rd_valid,
   input  logic              mvu_rd_ready,
   input  logic              mvu_rd_rvalid,
   input  logic [MVU_DW-1:0] mvu_rd_rdata,
   output logic [31:0]       dest_address,
   output logic [SYS_DW-1:0] dest_data,
   output logic              dest_valid,
   input  logic              dest_ready,
   input  logic              i_icb_cmd_valid,
   output logic              i_icb_cmd_ready,
   input  logic [31:0]       i_icb_cmd_addr,
   input  logic              i_icb_cmd_read,
   input  logic [31:0]       i_icb_cmd_wdata,
   input  logic [3:0]        i_icb_cmd_wmask,
   output logic              i_icb_rsp_valid,
   input  logic              i_icb_rsp_ready,
   output logic              i_icb_rsp_err,
   output logic [31:0]       i_icb_rsp_rdata,
   output logic              dma_irq
);

   state_e            state_q, state_d;
   logic [MVU_AW-1:0] rd_addr_q, rd_addr_d;
   logic [31:0]       dest_addr_q, dest_addr_d;
   logic [15:0]       wr_left_q, wr_left_d;   // words not yet fully written
   logic [MVU_DW-1:0] cur_q, cur_d;           // word being written
   logic [MVU_DW-1:0] buf_q, buf_d;           // prefetched next word
   logic              buf_vld_q, buf_vld_d;
   logic              rd_out_q, rd_out_d;     // read accepted, data not yet returned
   logic [MVU_AW-1:0] cfg_src;
   logic [31:0]       cfg_dst;
   logic [15:0]       cfg_size;
   logic              start, busy, done_set, pf_issue, rd_fire, in_wr;

   mvu_dma_wb_reg #(
      .MVU_AW(MVU_AW)
   ) u_reg (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_icb_cmd_valid (i_icb_cmd_valid),
      .i_icb_cmd_ready (i_icb_cmd_ready),
      .i_icb_cmd_addr  (i_icb_cmd_addr),
      .i_icb_cmd_read  (i_icb_cmd_read),
      .i_icb_cmd_wdata (i_icb_cmd_wdata),
      .i_icb_cmd_wmask (i_icb_cmd_wmask),
      .i_icb_rsp_valid (i_icb_rsp_valid),
      .i_icb_rsp_ready (i_icb_rsp_ready),
      .i_icb_rsp_err   (i_icb_rsp_err),
      .i_icb_rsp_rdata (i_icb_rsp_rdata),
      .cfg_src         (cfg_src),
      .cfg_dst         (cfg_dst),
      .cfg_size        (cfg_size),
      .start           (start),
      .busy            (busy),
      .done_set        (done_set),
      .irq             (dma_irq)
   );

   assign busy  = (state_q != StIdle);
   assign in_wr = (state_q == StWrLo) || (state_q == StWrHi);

`ifdef MVU_DMA_WB_PREFETCH_EN
   // Another word still needs reading only if more than the current one remains.
   assign pf_issue = in_wr && (wr_left_q > 16'd1) && !rd_out_q && !buf_vld_q;
`else
   assign pf_issue = 1'b0;
`endif

   assign mvu_rd_valid   = (state_q == StRdReq) || pf_issue;
   assign mvu_rd_address = rd_addr_q;
   assign rd_fire        = mvu_rd_valid && mvu_rd_ready;
   assign dest_valid     = in_wr;
   assign dest_address   = dest_addr_q;
   assign dest_data      = (state_q == StWrHi) ? cur_q[MVU_DW-1:SYS_DW] :
                           (state_q == StWrLo) ? cur_q[SYS_DW-1:0] : '0;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      dest_addr_d = dest_addr_q;
      wr_left_d   = wr_left_q;
      cur_d       = cur_q;
      buf_d       = buf_q;
      buf_vld_d   = buf_vld_q;
      rd_out_d    = rd_out_q;
      done_set    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               rd_addr_d   = cfg_src;
               dest_addr_d = cfg_dst;
               wr_left_d   = cfg_size;
               state_d     = (cfg_size == 16'd0) ? StDone : StRdReq;
            end
         end
         StRdReq: begin
            if (mvu_rd_ready) state_d = StRdWait;
         end
         StRdWait: begin
            if (mvu_rd_rvalid) begin
               cur_d   = mvu_rd_rdata;
               state_d = StWrLo;
            end
         end
         StWrLo: begin
            if (dest_ready) begin
               dest_addr_d = dest_addr_q + 32'd4;
               state_d     = StWrHi;
            end
         end
         StWrHi: begin
            if (dest_ready) begin
               dest_addr_d = dest_addr_q + 32'd4;
               wr_left_d   = wr_left_q - 16'd1;
               if (wr_left_q == 16'd1) begin
                  state_d = StDone;
               end else if (buf_vld_q) begin
                  cur_d     = buf_q;
                  buf_vld_d = 1'b0;
                  state_d   = StWrLo;
               end else if (mvu_rd_rvalid && rd_out_q) begin
                  // Data arriving exactly as the last beat leaves: forward directly.
                  cur_d   = mvu_rd_rdata;
                  state_d = StWrLo;
               end else if (rd_out_q || rd_fire) begin
                  state_d = StRdWait;
               end else begin
                  state_d = StRdReq;
               end
            end
         end
         StDone: begin
            done_set = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Read-side bookkeeping shared by the sequential and prefetch paths.
      if (mvu_rd_rvalid && rd_out_q) begin
         rd_out_d = 1'b0;
         if (in_wr && !(state_q == StWrHi && dest_ready)) begin
            buf_d     = mvu_rd_rdata;
            buf_vld_d = 1'b1;
         end
      end
      if (rd_fire) begin
         rd_out_d  = 1'b1;
         rd_addr_d = rd_addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rd_addr_q   <= '0;
         dest_addr_q <= '0;
         wr_left_q   <= '0;
         cur_q       <= '0;
         buf_q       <= '0;
         buf_vld_q   <= 1'b0;
         rd_out_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         dest_addr_q <= dest_addr_d;
         wr_left_q   <= wr_left_d;
         cur_q       <= cur_d;
         buf_q       <= buf_d;
         buf_vld_q   <= buf_vld_d;
         rd_out_q    <= rd_out_d;
      end
   end

endmodule

// File: tb/tb_mvu_dma_wb.sv
// Self-checking bench for mvu_dma_wb: random MVU latency and dest back-pressure,
// expected read addresses and write beats derived from a memory array and the
// programmed SRC/DST/SIZE.
module tb_mvu_dma_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] mvu_rd_address;
   logic        mvu_rd_valid, mvu_rd_ready, mvu_rd_rvalid;
   logic [63:0] mvu_rd_rdata;
   logic [31:0] dest_address, dest_data;
   logic        dest_valid, dest_ready;
   logic        i_icb_cmd_valid, i_icb_cmd_ready, i_icb_cmd_read;
   logic [31:0] i_icb_cmd_addr, i_icb_cmd_wdata;
   logic [3:0]  i_icb_cmd_wmask;
   logic        i_icb_rsp_valid, i_icb_rsp_ready, i_icb_rsp_err;
   logic [31:0] i_icb_rsp_rdata;
   logic        dma_irq;

   mvu_dma_wb dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mvu_rd_address  (mvu_rd_address),
      .mvu_rd_valid    (mvu_rd_valid),
      .mvu_rd_ready    (mvu_rd_ready),
      .mvu_rd_rvalid   (mvu_rd_rvalid),
      .mvu_rd_rdata    (mvu_rd_rdata),
      .dest_address    (dest_address),
      .dest_data       (dest_data),
      .dest_valid      (dest_valid),
      .dest_ready      (dest_ready),
      .i_icb_cmd_valid (i_icb_cmd_valid),
      .i_icb_cmd_ready (i_icb_cmd_ready),
      .i_icb_cmd_addr  (i_icb_cmd_addr),
      .i_icb_cmd_read  (i_icb_cmd_read),
      .i_icb_cmd_wdata (i_icb_cmd_wdata),
      .i_icb_cmd_wmask (i_icb_cmd_wmask),
      .i_icb_rsp_valid (i_icb_rsp_valid),
      .i_icb_rsp_ready (i_icb_rsp_ready),
      .i_icb_rsp_err   (i_icb_rsp_err),
      .i_icb_rsp_rdata (i_icb_rsp_rdata),
      .dma_irq         (dma_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] a;
      int          due;
   } pend_t;

   logic [63:0] mem [0:32767];
   logic [14:0] exp_rd[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   pend_t       pend[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          n_rdv = 0;
   int          n_dv = 0;
   int          beat_idx = 0;
   int          stall_beat = -1;
   int          stall_left = 0;
   bit          rand_ready = 1'b0;
   bit          held = 1'b0;
   logic [31:0] held_addr, held_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // MVU RAM responder and dest sink; inputs change on the falling edge only.
   initial begin
      mvu_rd_ready  = 1'b0;
      mvu_rd_rvalid = 1'b0;
      mvu_rd_rdata  = '0;
      dest_ready    = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            pend.delete();
            mvu_rd_rvalid = 1'b0;
            held          = 1'b0;
         end else begin
            if (mvu_rd_valid) n_rdv++;
            if (dest_valid) n_dv++;
            mvu_rd_rvalid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
               mvu_rd_rvalid = 1'b1;
               mvu_rd_rdata  = mem[pend[0].a];
               void'(pend.pop_front());
            end
            mvu_rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mvu_rd_valid && mvu_rd_ready) begin
               pend_t p;
               if (exp_rd.size() == 0) check("rd_extra", mvu_rd_valid, 0);
               else check("rd_addr", mvu_rd_address, exp_rd.pop_front());
               p.a   = mvu_rd_address;
               p.due = cyc + int'($urandom_range(1, 3));
               pend.push_back(p);
            end
            if (stall_left > 0 && dest_valid && beat_idx == stall_beat) begin
               dest_ready = 1'b0;
               stall_left--;
            end else begin
               dest_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (dest_valid && held) begin
               check("hold_addr", dest_address, held_addr);
               check("hold_data", dest_data, held_data);
            end
            if (dest_valid && dest_ready) begin
               if (exp_addr.size() == 0) check("beat_extra", dest_valid, 0);
               else begin
                  check("beat_addr", dest_address, exp_addr.pop_front());
                  check("beat_data", dest_data, exp_data.pop_front());
               end
               beat_idx++;
            end
            held      = dest_valid && !dest_ready;
            held_addr = dest_address;
            held_data = dest_data;
         end
      end
   end

   task automatic icb_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
      int n = 0;
      @(negedge clk);
      i_icb_cmd_valid = 1'b1;
      i_icb_cmd_read  = rd;
      i_icb_cmd_addr  = addr;
      i_icb_cmd_wdata = wdata;
      while (!i_icb_cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      i_icb_cmd_valid = 1'b0;
      check("icb_rsp_valid", i_icb_rsp_valid, 1);
      rdata = i_icb_rsp_rdata;
      err   = i_icb_rsp_err;
   endtask

   task automatic icb_write(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] d;
      logic e;
      icb_xfer(1'b0, addr, wdata, d, e);
   endtask

   task automatic icb_read(input logic [31:0] addr, output logic [31:0] d);
      logic e;
      icb_xfer(1'b1, addr, 32'h0, d, e);
   endtask

   // Expected traffic: word i comes from src+i (mod 2^15), lands at dst+8i (mod 2^32).
   task automatic plan(input logic [14:0] src, input logic [31:0] dst, input int size);
      for (int i = 0; i < size; i++) begin
         logic [14:0] wa;
         wa = src + 15'(i);
         exp_rd.push_back(wa);
         exp_addr.push_back(dst + 32'(8 * i));
         exp_data.push_back(mem[wa][31:0]);
         exp_addr.push_back(dst + 32'(8 * i + 4));
         exp_data.push_back(mem[wa][63:32]);
      end
   endtask

   task automatic start_xfer(input logic [14:0] src, input logic [31:0] dst,
                             input logic [15:0] size, input logic irq_en);
      icb_write(32'h00, 32'(src));
      icb_write(32'h04, dst);
      icb_write(32'h08, 32'(size));
      plan(src, dst, int'(size));
      beat_idx = 0;
      icb_write(32'h0C, {30'b0, irq_en, 1'b1});
   endtask

   task automatic finish_xfer(input logic irq_en);
      logic [31:0] st;
      int n = 0;
      icb_read(32'h10, st);
      while (st[0] && n < 400) begin
         icb_read(32'h10, st);
         n++;
      end
      check("idle_reached", st[0], 0);
      check("status_done", st[1], 1);
      check("beats_left", exp_addr.size(), 0);
      check("reads_left", exp_rd.size(), 0);
      check("irq", dma_irq, irq_en);
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          base;
      rst_n           = 1'b0;
      i_icb_cmd_valid = 1'b0;
      i_icb_cmd_read  = 1'b0;
      i_icb_cmd_addr  = '0;
      i_icb_cmd_wdata = '0;
      i_icb_cmd_wmask = 4'hF;
      i_icb_rsp_ready = 1'b1;
      for (int i = 0; i < 32768; i++) mem[i] = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      check("rst_mvu", {mvu_rd_valid, mvu_rd_address}, 0);
      check("rst_dest", {dest_valid, dest_address, dest_data}, 0);
      check("rst_icb", {i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata}, 0);
      check("rst_irq", dma_irq, 0);
      rst_n = 1'b1;
      for (int r = 0; r < 5; r++) begin
         icb_read(32'(4 * r), d);
         check("rst_reg", d, 0);
      end

      // Basic two-word transfer, ideal sink.
      mem[16] = 64'h1111_2222_3333_4444;
      mem[17] = 64'h5555_6666_7777_8888;
      start_xfer(15'h0010, 32'h8000_0000, 16'd2, 1'b1);
      finish_xfer(1'b1);

      // Same transfer with the third beat stalled for 5 cycles.
      stall_beat = 2;
      stall_left = 5;
      start_xfer(15'h0010, 32'h8000_0000, 16'd2, 1'b1);
      finish_xfer(1'b1);
      check("stall_used", stall_left, 0);
      stall_beat = -1;

      // SIZE=0: done one cycle after start, no traffic.
      base = n_rdv + n_dv;
      icb_write(32'h08, 32'h0);
      icb_write(32'h0C, 32'h3);
      check("sz0_irq_cleared", dma_irq, 0);
      @(negedge clk);
      check("sz0_irq_next", dma_irq, 1);
      icb_read(32'h10, d);
      check("sz0_status", d[1:0], 2'b10);
      check("sz0_no_traffic", n_rdv + n_dv - base, 0);

      // Address wrap on both sides.
      rand_ready = 1'b1;
      start_xfer(15'h7FFF, 32'hFFFF_FFF8, 16'd2, 1'b0);
      finish_xfer(1'b0);

      // Writes while busy are ignored.
      stall_beat = 0;
      stall_left = 40;
      start_xfer(15'h0123, 32'h4000_0000, 16'd4, 1'b1);
      icb_write(32'h04, 32'h1234_5678);
      icb_write(32'h0C, 32'h3);
      icb_read(32'h04, d);
      check("busy_dst_kept", d, 32'h4000_0000);
      icb_read(32'h10, d);
      check("busy_status", d[0], 1);
      finish_xfer(1'b1);
      stall_beat = -1;

      // Unmapped offset and W1C of done.
      icb_xfer(1'b1, 32'h14, 32'h0, d, e);
      check("unmapped_err", e, 1);
      check("unmapped_rdata", d, 0);
      icb_write(32'h10, 32'h2);
      icb_read(32'h10, d);
      check("w1c_done", d[1], 0);
      check("w1c_irq", dma_irq, 0);

      // Randomized transfers.
      for (int t = 0; t < 6; t++) begin
         logic en;
         en = 1'($urandom_range(0, 1));
         start_xfer(15'($urandom), $urandom, 16'($urandom_range(1, 5)), en);
         finish_xfer(en);
      end

      // Asynchronous reset during the high beat, then a clean transfer.
      start_xfer(15'h0200, 32'h2000_0000, 16'd3, 1'b1);
      begin
         int n = 0;
         while (!(dest_valid && dest_address[2]) && n < 300) begin
            @(negedge clk);
            n++;
         end
         check("reached_wr_hi", dest_valid && dest_address[2], 1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_mvu", {mvu_rd_valid, mvu_rd_address}, 0);
      check("arst_dest", {dest_valid, dest_address, dest_data}, 0);
      check("arst_irq", dma_irq, 0);
      exp_rd.delete();
      exp_addr.delete();
      exp_data.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      icb_read(32'h10, d);
      check("arst_status", d, 0);
      start_xfer(15'h0300, 32'h3000_0000, 16'd3, 1'b1);
      finish_xfer(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
